// File: rtl/phase_bank_mv.sv
// phase_bank_mv: multi-voice phase accumulator bank.
// NVOICES phase accumulators share one adder, serviced round-robin by a slot
// pointer that advances on each clk_en cycle. A one-entry command buffer takes
// NOTE_ON / NOTE_OFF / RETUNE commands at any clock edge and applies them on
// the next clk_en cycle.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (dominates clk_en)
//   clk_en          sample-slot enable
//   i_cmd_*         command handshake: valid/op/voice/midi/tw; o_cmd_ready = buffer empty
//   o_cmd_err       one-cycle pulse when an applied command addressed a voice >= NVOICES
//   o_valid/o_voice/o_midi/o_phase/o_frame   registered output slot (pre-add phase)
//   o_active        per-voice active bitmap
module phase_bank_mv #(
  parameter int NVOICES       = 10,
  parameter int PW            = 24,
  parameter int OW            = 16,
  parameter int RESET_ON_NOTE = 1,
  localparam int VW           = $clog2(NVOICES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [VW-1:0]      i_cmd_voice,
  input  logic [6:0]         i_cmd_midi,
  input  logic [PW-1:0]      i_cmd_tw,
  output logic               o_cmd_err,
  output logic               o_valid,
  output logic [VW-1:0]      o_voice,
  output logic [6:0]         o_midi,
  output logic [OW-1:0]      o_phase,
  output logic               o_frame,
  output logic [NVOICES-1:0] o_active
);

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_NOTE_ON  = 2'b01,
    OP_NOTE_OFF = 2'b10,
    OP_RETUNE   = 2'b11
  } cmd_op_e;

  logic [PW-1:0]      phase_q [NVOICES];
  logic [PW-1:0]      phase_d [NVOICES];
  logic [PW-1:0]      tw_q    [NVOICES];
  logic [PW-1:0]      tw_d    [NVOICES];
  logic [6:0]         midi_q  [NVOICES];
  logic [6:0]         midi_d  [NVOICES];
  logic [NVOICES-1:0] active_q, active_d;
  logic [VW-1:0]      slot_q, slot_d;

  logic               buf_valid_q;
  cmd_op_e            buf_op_q;
  logic [VW-1:0]      buf_voice_q;
  logic [6:0]         buf_midi_q;
  logic [PW-1:0]      buf_tw_q;

  logic               err_q, valid_q, frame_q;
  logic [VW-1:0]      voice_q;
  logic [6:0]         midi_out_q;
  logic [OW-1:0]      phase_out_q;

  logic               apply, voice_ok;
  logic [OW-1:0]      sl_phase;
  logic [6:0]         sl_midi;
  logic               sl_active;

  assign apply    = clk_en && buf_valid_q;
  assign voice_ok = int'(buf_voice_q) < NVOICES;
  assign slot_d   = (slot_q == VW'(NVOICES - 1)) ? '0 : slot_q + 1'b1;

  // Read port for the current slot (pre-command, pre-add state).
  always_comb begin
    sl_phase  = '0;
    sl_midi   = '0;
    sl_active = 1'b0;
    for (int v = 0; v < NVOICES; v++) begin
      if (v == int'(slot_q)) begin
        sl_phase  = phase_q[v][PW-1 -: OW];
        sl_midi   = midi_q[v];
        sl_active = active_q[v];
      end
    end
  end

  // Accumulate first, then let the command overwrite the fields it owns, so a
  // command hitting the current slot wins over this cycle's add.
  always_comb begin
    phase_d  = phase_q;
    tw_d     = tw_q;
    midi_d   = midi_q;
    active_d = active_q;
    for (int v = 0; v < NVOICES; v++) begin
      if (v == int'(slot_q) && active_q[v]) begin
        phase_d[v] = phase_q[v] + tw_q[v];
      end
    end
    if (apply && voice_ok) begin
      for (int v = 0; v < NVOICES; v++) begin
        if (v == int'(buf_voice_q)) begin
          case (buf_op_q)
            OP_NOTE_ON: begin
              if (buf_midi_q != 7'd0) begin
                midi_d[v]   = buf_midi_q;
                tw_d[v]     = buf_tw_q;
                active_d[v] = 1'b1;
                if (RESET_ON_NOTE != 0) phase_d[v] = '0;
              end else begin
                // midi 0 behaves exactly like NOTE_OFF
                midi_d[v]   = '0;
                active_d[v] = 1'b0;
              end
            end
            OP_NOTE_OFF: begin
              midi_d[v]   = '0;
              active_d[v] = 1'b0;
            end
            OP_RETUNE: tw_d[v] = buf_tw_q;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NVOICES; v++) begin
        phase_q[v] <= '0;
        tw_q[v]    <= '0;
        midi_q[v]  <= '0;
      end
      active_q    <= '0;
      slot_q      <= '0;
      buf_valid_q <= 1'b0;
      buf_op_q    <= OP_NOP;
      buf_voice_q <= '0;
      buf_midi_q  <= '0;
      buf_tw_q    <= '0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
      voice_q     <= '0;
      midi_out_q  <= '0;
      phase_out_q <= '0;
    end else begin
      if (clk_en) begin
        phase_q     <= phase_d;
        tw_q        <= tw_d;
        midi_q      <= midi_d;
        active_q    <= active_d;
        slot_q      <= slot_d;
        voice_q     <= slot_q;
        valid_q     <= sl_active;
        midi_out_q  <= sl_active ? sl_midi : '0;
        phase_out_q <= sl_active ? sl_phase : '0;
        frame_q     <= (slot_q == '0);
      end
      // The apply cycle frees the buffer but cannot refill it: ready is still low.
      if (buf_valid_q) begin
        if (clk_en) buf_valid_q <= 1'b0;
      end else if (i_cmd_valid) begin
        buf_valid_q <= 1'b1;
        buf_op_q    <= cmd_op_e'(i_cmd_op);
        buf_voice_q <= i_cmd_voice;
        buf_midi_q  <= i_cmd_midi;
        buf_tw_q    <= i_cmd_tw;
      end
      err_q <= apply && !voice_ok;
    end
  end

  assign o_cmd_ready = !buf_valid_q;
  assign o_cmd_err   = err_q;
  assign o_valid     = valid_q;
  assign o_voice     = voice_q;
  assign o_midi      = midi_out_q;
  assign o_phase     = phase_out_q;
  assign o_frame     = frame_q;
  assign o_active    = active_q;

endmodule

// File: doc/phase_bank_mv.md
# phase_bank_mv

Multi-voice, parametrised phase accumulator bank: the next generation of the pipelined phase bank. It holds NVOICES independent phase accumulators, time-multiplexed onto one adder. Each voice is controlled individually through a handshaked command port (note-on, note-off, retune). Its output is a round-robin stream of (voice, midi, phase) samples that feeds the waveform lookup stage.

## Interface
Parameters:
- NVOICES, 10: number of voices/accumulators, ≥2.
- PW, 24: accumulator and tuning-word width in bits.
- OW, 16: output phase width, OW ≤ PW. Output is the top OW bits of the accumulator.
- RESET_ON_NOTE, 1: 1 = note-on clears the voice phase; 0 = the phase free-runs across notes.
- VW, $clog2(NVOICES): voice index width (derived; do not override).

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset; dominates clk_en.
- clk_en, in, 1: sample-slot enable; the pipeline advances only when high.
- i_cmd_valid, in, 1: command valid.
- o_cmd_ready, out, 1: command buffer empty.
- i_cmd_op, in, 2: command opcode. 00 = NOP, 01 = NOTE_ON, 10 = NOTE_OFF, 11 = RETUNE.
- i_cmd_voice, in, VW: target voice.
- i_cmd_midi, in, 7: MIDI note (NOTE_ON only).
- i_cmd_tw, in, PW: tuning word (NOTE_ON and RETUNE).
- o_cmd_err, out, 1: one-cycle pulse when an applied command had i_cmd_voice ≥ NVOICES.
- o_valid, out, 1: the output slot holds an active voice.
- o_voice, out, VW: voice index of the output slot.
- o_midi, out, 7: note of the output slot; 0 when inactive.
- o_phase, out, OW: phase of the output slot; 0 when inactive.
- o_frame, out, 1: high when o_voice == 0 (first slot of a frame).
- o_active, out, NVOICES: per-voice active bitmap.

## Operation
- Per-voice state: phase[v] (PW bits), tw[v] (PW bits), midi[v] (7 bits), active[v].
- Slot pointer s (VW bits) runs 0..NVOICES-1 and wraps to 0. It advances once per clk_en cycle.

On each clk_en cycle, slot s does two things:
- Output register: o_voice ← s, o_midi ← midi[s], o_valid ← active[s], o_phase ← active[s] ? phase[s][PW-1 -: OW] : 0, o_frame ← (s == 0).
- Accumulate: phase[s] ← active[s] ? phase[s] + tw[s] (mod 2^PW, carry dropped) : phase[s].
- Each voice therefore advances once per NVOICES enabled cycles. Emitted phase is the pre-add value.

Command buffer (one entry):
- A command is accepted on any clk edge with i_cmd_valid && o_cmd_ready, independent of clk_en.
- On acceptance the command is latched and o_cmd_ready drops.
- The buffered command is applied on the next clk_en cycle. That same cycle frees the buffer, so o_cmd_ready = 1 on the following edge.
- A new command cannot be accepted in the apply cycle, because ready is still low.

Command semantics when applied to voice v:
- NOTE_ON: midi[v] ← i_cmd_midi, tw[v] ← i_cmd_tw, active[v] ← (i_cmd_midi != 0). If RESET_ON_NOTE, phase[v] ← 0. NOTE_ON with midi 0 is treated as NOTE_OFF.
- NOTE_OFF: active[v] ← 0, midi[v] ← 0. Phase is retained; tw is retained.
- RETUNE: tw[v] ← i_cmd_tw only. Phase, midi and active are unchanged, giving glitch-free pitch bend. RETUNE on an inactive voice stores tw only.
- NOP: no effect; still consumes one clk_en cycle.
- v ≥ NVOICES: no state change; o_cmd_err pulses one cycle.
- o_active reflects active[] registered, updated in the apply cycle.

Collision (command voice == s in the same cycle): the command's writes take precedence over the accumulate for the fields it writes.
- NOTE_ON with RESET_ON_NOTE leaves phase[s] = 0 (no add).
- RETUNE: this cycle's add uses the old tw; the new tw is stored.
- The output register always samples pre-command state.

## Timing
- Reset (rst high at a clk edge) forces: all phase/tw/midi = 0, active = 0, s = 0, buffer empty.
- Reset output values: o_cmd_ready = 1, o_valid = 0, o_voice = 0, o_midi = 0, o_phase = 0, o_frame = 0, o_cmd_err = 0, o_active = 0.
- Reset mid-command discards the buffered command.
- Slot latency: state of slot s appears on the outputs 1 clk edge after the clk_en cycle that selects s. Outputs hold while clk_en is low.
- Command-to-effect latency: the command is applied at the first clk_en cycle after acceptance. The first output reflecting it is the next visit of voice v: 1 to NVOICES clk_en cycles later.
- With clk_en held high, throughput is one command per 2 cycles.
- With clk_en low, the buffer holds and ready stays low indefinitely.

## Test plan
- Reset then NOTE_ON v3, midi 0x45, tw 0x001000, clk_en always 1, NVOICES = 10, PW = 24, OW = 16 → successive v3 slots give o_phase 0x0000, 0x0010, 0x0020…; other slots show o_valid = 0, o_phase = 0; o_frame high every 10th cycle.
- Wrap-around: NOTE_ON v0 with tw 0x800001 → v0 phases 0x0000, 0x8000, 0x0000 (carry dropped, accumulator 0x000002), 0x8000.
- RETUNE v3 mid-note from 0x001000 to 0x002000 → phase continues from its current value with step 0x0020 in OW units, no reset; o_midi stays 0x45.
- Collision: NOTE_ON targeting the voice currently at s with RESET_ON_NOTE = 1 → that voice's next output phase is 0, the old tw is not added; NOTE_OFF v3 → v3 slots give o_valid = 0, and o_active bit 3 clears in the apply cycle.
- Handshake: i_cmd_valid held high with clk_en toggling 1-in-4 → exactly one accept per clk_en pulse; ready low between; voice 12 with NVOICES = 10 → o_cmd_err pulse, no state change.
- Sync rst asserted with a command buffered and voices active → all outputs at reset values next edge, o_cmd_ready = 1, the buffered command never applied.
